conv_row_stream: RTL

- Parametrised streaming row convolver: one input beat carries LANES+TAPS-1 pixels and produces LANES filtered pixels.
- Generalises the fixed 128-lane, 3-tap smoothing array with:
  - configurable lane count, tap count and widths;
  - signed weights, rounding normalisation shift and saturation;
  - bypass mode;
  - valid/ready handshaking with backpressure through a 2-stage pipeline.
- Sits between the row-window fetcher and the result writer in the image smoother datapath.

---
 rtl/conv_row_stream.sv | 125 ++++++++++++
 1 files changed

// File: rtl/conv_row_stream.sv
// rtl/conv_row_stream.sv - streaming row convolver, LANES outputs per beat, 2-stage valid/ready pipeline
// S1 holds per-tap products, S2 holds the summed, rounded, clamped lanes and drives the outputs.
module conv_row_stream #(
  parameter int LANES = 128,
  parameter int PIX_W = 8,
  parameter int TAPS  = 3,
  parameter int W_W   = 8,
  parameter int SHIFT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [(LANES+TAPS-1)*PIX_W-1:0]   in_data,
  input  logic                              in_last,
  input  logic [TAPS*W_W-1:0]               weight,
  input  logic                              bypass,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*PIX_W-1:0]            out_data,
  output logic                              out_last,
  output logic                              out_sat
);

  localparam int CTR    = (TAPS - 1) / 2;
  localparam int PROD_W = PIX_W + W_W;
  localparam int ACC_W  = PIX_W + W_W + $clog2(TAPS) + 1;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((2 ** SHIFT) / 2);
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((2 ** PIX_W) - 1);

  logic s1_valid, s1_last, s1_byp, s2_valid;
  logic s1_adv, s2_adv;

  logic signed [PROD_W-1:0] prod_d  [LANES][TAPS];
  logic signed [PROD_W-1:0] s1_prod [LANES][TAPS];
  logic        [PIX_W-1:0]  s1_ctr  [LANES];

  logic signed [PROD_W-1:0] px_ext, wt_ext;
  logic signed [ACC_W-1:0]  acc, r;
  logic [LANES*PIX_W-1:0]   lane_d;
  logic                     sat_d;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Pixels are unsigned: zero-extend before the signed multiply.
  always_comb begin
    px_ext = '0;
    wt_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < TAPS; j++) begin
        px_ext = $signed({{W_W{1'b0}}, in_data[(i+j)*PIX_W +: PIX_W]});
        wt_ext = $signed({{PIX_W{weight[j*W_W+W_W-1]}}, weight[j*W_W +: W_W]});
        prod_d[i][j] = px_ext * wt_ext;
      end
    end
  end

  always_comb begin
    lane_d = '0;
    sat_d  = 1'b0;
    acc    = '0;
    r      = '0;
    for (int i = 0; i < LANES; i++) begin
      acc = '0;
      for (int j = 0; j < TAPS; j++) begin
        acc = acc + ACC_W'(s1_prod[i][j]);
      end
      r = (acc + RND) >>> SHIFT;
      if (s1_byp) begin
        lane_d[i*PIX_W +: PIX_W] = s1_ctr[i];
      end else if (r[ACC_W-1]) begin
        lane_d[i*PIX_W +: PIX_W] = '0;
        sat_d = 1'b1;
      end else if (r > PMAX) begin
        lane_d[i*PIX_W +: PIX_W] = '1;
        sat_d = 1'b1;
      end else begin
        lane_d[i*PIX_W +: PIX_W] = r[PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_byp   <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sat  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_ctr[i] <= '0;
        for (int j = 0; j < TAPS; j++) begin
          s1_prod[i][j] <= '0;
        end
      end
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_prod <= prod_d;
          s1_last <= in_last;
          s1_byp  <= bypass;
          for (int i = 0; i < LANES; i++) begin
            s1_ctr[i] <= in_data[(i+CTR)*PIX_W +: PIX_W];
          end
        end
      end
      // Output registers only load on a real beat, so a stalled beat stays put.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= lane_d;
          out_last <= s1_last;
          out_sat  <= sat_d;
        end
      end
    end
  end

endmodule
